// File: rtl/xbar_slave_port.sv
`default_nettype none
// ============================================================================
// Module   : xbar_slave_port
// Purpose  : Slave-side stage of the cross-bar. It sits behind the per-slave
//            round-robin arbiter, takes the arbiter's one-hot grant, and
//            latches the winning master's transaction. It then drives that
//            transaction onto the slave bus, routes the ack and read data back
//            to the owning master only, and pulses arb_ack to the arbiter
//            when the transaction completes.
// Ports    : clk, rst (async, active-low)
//            grant    [N]     one-hot grant from arbiter
//            arb_ack          completion pulse to arbiter
//            m_req    [N]     per-master request
//            m_addr   [N*AW]  per-master address (master i at [i*AW +: AW])
//            m_cmd    [N]     per-master command (0 read, 1 write)
//            m_wdata  [N*DW]  per-master write data (master i at [i*DW +: DW])
//            m_ack    [N]     per-master ack (pass-through of s_ack to owner)
//            m_rvalid [N]     per-master read-data-valid
//            m_rdata  [DW]    shared read data, qualified by m_rvalid
//            s_req, s_addr, s_cmd, s_wdata  slave request bus
//            s_ack, s_rdata                 slave response
// Revision : 1.0 - initial release
// ============================================================================
module xbar_slave_port #(
    parameter int N  = 2,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    grant,
    output logic            arb_ack,
    input  logic [N-1:0]    m_req,
    input  logic [N*AW-1:0] m_addr,
    input  logic [N-1:0]    m_cmd,
    input  logic [N*DW-1:0] m_wdata,
    output logic [N-1:0]    m_ack,
    output logic [N-1:0]    m_rvalid,
    output logic [DW-1:0]   m_rdata,
    output logic            s_req,
    output logic [AW-1:0]   s_addr,
    output logic            s_cmd,
    output logic [DW-1:0]   s_wdata,
    input  logic            s_ack,
    input  logic [DW-1:0]   s_rdata
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RDATA = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [N-1:0]    owner_onehot;

    logic            grant_onehot;
    logic [IW-1:0]   grant_idx;
    logic            capture;

    // A grant is only honoured when exactly one bit is set; x & (x-1) clears
    // the lowest set bit, so a zero result means at most one bit was set.
    assign grant_onehot = (grant != '0) && ((grant & (grant - N'(1))) == '0);

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx = IW'(i);
            end
        end
    end

    assign capture      = grant_onehot && ((grant & m_req) != '0);
    assign owner_onehot = N'(1) << owner;

    // The slave's ack is forwarded combinationally to the owner so the master
    // sees it in the same cycle the slave accepts the request.
    always_comb begin
        m_ack = '0;
        if ((state == REQ) && s_ack) begin
            m_ack = owner_onehot;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= '0;
            s_req    <= 1'b0;
            s_addr   <= '0;
            s_cmd    <= 1'b0;
            s_wdata  <= '0;
            m_rdata  <= '0;
            m_rvalid <= '0;
            arb_ack  <= 1'b0;
        end else begin
            // Completion strobes are single-cycle; they are re-armed only on
            // the transition into DONE.
            arb_ack  <= 1'b0;
            m_rvalid <= '0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        owner   <= grant_idx;
                        s_addr  <= m_addr[grant_idx*AW +: AW];
                        s_cmd   <= m_cmd[grant_idx];
                        s_wdata <= m_wdata[grant_idx*DW +: DW];
                        s_req   <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (s_ack) begin
                        s_req <= 1'b0;
                        if (s_cmd) begin
                            arb_ack <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state   <= RDATA;
                        end
                    end
                end
                RDATA: begin
                    // Slave read data arrives one cycle after its ack.
                    m_rdata  <= s_rdata;
                    m_rvalid <= owner_onehot;
                    arb_ack  <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xbar_slave_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_xbar_slave_port
// Purpose  : Self-checking bench for xbar_slave_port. A vector table drives
//            master transactions and slave responses; a scoreboard queue holds
//            the expected slave-bus transaction and completion for each
//            captured grant and is compared by a monitor on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xbar_slave_port;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    grant;
    logic            arb_ack;
    logic [N-1:0]    m_req;
    logic [N*AW-1:0] m_addr;
    logic [N-1:0]    m_cmd;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]    m_ack;
    logic [N-1:0]    m_rvalid;
    logic [DW-1:0]   m_rdata;
    logic            s_req;
    logic [AW-1:0]   s_addr;
    logic            s_cmd;
    logic [DW-1:0]   s_wdata;
    logic            s_ack;
    logic [DW-1:0]   s_rdata;

    xbar_slave_port #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .grant    (grant),
        .arb_ack  (arb_ack),
        .m_req    (m_req),
        .m_addr   (m_addr),
        .m_cmd    (m_cmd),
        .m_wdata  (m_wdata),
        .m_ack    (m_ack),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .s_req    (s_req),
        .s_addr   (s_addr),
        .s_cmd    (s_cmd),
        .s_wdata  (s_wdata),
        .s_ack    (s_ack),
        .s_rdata  (s_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] grant;
        logic [N-1:0] mreq;
        logic [N-1:0] grant_after;   // grant presented while the port is busy
        int           owner;
        logic         cmd;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [31:0]  rdata;
        int           delay;         // REQ cycles before the slave acks
        logic         cap;           // capture expected
    } vec_t;

    typedef struct {
        int          owner;
        logic        cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    vec_t        tbl [8];
    exp_t        sbq [$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: slave-bus contents and completions vs queue.
    always @(negedge clk) begin
        exp_t        e;
        logic [N-1:0] oh;
        chk("m_ack_onehot0", 64'($onehot0(m_ack)), 64'd1);
        if (s_req && s_ack) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_slave_ack: got s_req&s_ack expected idle bus at %0t", $time);
            end else begin
                e  = sbq[0];
                oh = 2'b1 << e.owner;
                chk("s_addr",  s_addr,  e.addr);
                chk("s_cmd",   s_cmd,   e.cmd);
                if (e.cmd) chk("s_wdata", s_wdata, e.wdata);
                chk("m_ack_route", m_ack, oh);
            end
        end
        if (arb_ack) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_arb_ack: got 1 expected 0 at %0t", $time);
            end else begin
                e  = sbq.pop_front();
                oh = 2'b1 << e.owner;
                chk("m_rvalid_done", m_rvalid, e.cmd ? 2'b00 : oh);
                if (!e.cmd) chk("m_rdata", m_rdata, e.rdata);
            end
        end else begin
            chk("m_rvalid_idle", m_rvalid, 2'b00);
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        m_req = v.mreq;
        grant = v.grant;
        m_cmd = v.cmd ? (2'b1 << v.owner) : ~(2'b1 << v.owner);
        for (int i = 0; i < N; i++) begin
            m_addr[i*AW +: AW]  = (i == v.owner) ? v.addr  : (v.addr  ^ 32'hFFFF_0000 ^ 32'(i));
            m_wdata[i*DW +: DW] = (i == v.owner) ? v.wdata : (v.wdata ^ 32'h5A5A_A5A5 ^ 32'(i));
        end
        if (v.cap) begin
            e.owner = v.owner; e.cmd = v.cmd; e.addr = v.addr;
            e.wdata = v.wdata; e.rdata = v.rdata;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        grant = v.grant_after;
        if (!v.cap) begin
            repeat (3) begin
                @(negedge clk);
                chk("nocap_s_req", s_req, 1'b0);
                chk("nocap_arb_ack", arb_ack, 1'b0);
            end
            grant = '0; m_req = '0;
            @(posedge clk); #1;
            return;
        end
        for (int k = 0; k <= v.delay; k++) begin
            s_ack = (k == v.delay);
            @(negedge clk);
            chk("req_s_req", s_req, 1'b1);
            chk("req_s_addr_held", s_addr, v.addr);
            @(posedge clk); #1;
        end
        s_ack = 1'b0; grant = '0; m_req = '0;
        if (!v.cmd) begin
            s_rdata = v.rdata;
            @(negedge clk);
            chk("rdata_s_req", s_req, 1'b0);
            chk("rdata_arb_ack", arb_ack, 1'b0);
            @(posedge clk); #1;
            s_rdata = $urandom;
            last_rdata = v.rdata;
        end
        @(negedge clk);
        chk("done_arb_ack", arb_ack, 1'b1);
        chk("done_s_req", s_req, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_arb_ack", arb_ack, 1'b0);
        chk("m_rdata_hold", m_rdata, last_rdata);
        @(posedge clk); #1;
    endtask

    initial begin
        //            grant  mreq   after  own cmd   addr          wdata         rdata        dly cap
        tbl[0] = '{2'b10, 2'b10, 2'b10, 1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        2, 1'b1};
        tbl[1] = '{2'b01, 2'b01, 2'b01, 0, 1'b0, 32'h0000_0040, 32'h0,         32'h1234_5678, 0, 1'b1};
        tbl[2] = '{2'b11, 2'b11, 2'b11, 0, 1'b1, 32'h0000_0500, 32'h1111_1111, 32'h0,        0, 1'b0};
        tbl[3] = '{2'b01, 2'b10, 2'b01, 0, 1'b1, 32'h0000_0600, 32'h2222_2222, 32'h0,        0, 1'b0};
        tbl[4] = '{2'b00, 2'b11, 2'b00, 0, 1'b0, 32'h0000_0700, 32'h3333_3333, 32'h0,        0, 1'b0};
        tbl[5] = '{2'b01, 2'b11, 2'b10, 0, 1'b1, 32'h0000_0200, 32'hA5A5_0F0F, 32'h0,        1, 1'b1};
        tbl[6] = '{2'b10, 2'b10, 2'b10, 1, 1'b0, 32'h0000_0ABC, 32'h0,         32'hCAFE_F00D, 3, 1'b1};
        tbl[7] = '{2'b10, 2'b10, 2'b10, 1, 1'b1, 32'hFFFF_FFFC, 32'h0BAD_CAFE, 32'h0,        0, 1'b1};

        rst = 1'b0; grant = '0; m_req = '0; m_addr = '0; m_cmd = '0;
        m_wdata = '0; s_ack = 1'b0; s_rdata = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_s_req",    s_req,    1'b0);
        chk("rst_s_addr",   s_addr,   32'h0);
        chk("rst_s_cmd",    s_cmd,    1'b0);
        chk("rst_s_wdata",  s_wdata,  32'h0);
        chk("rst_m_rdata",  m_rdata,  32'h0);
        chk("rst_m_rvalid", m_rvalid, 2'b00);
        chk("rst_arb_ack",  arb_ack,  1'b0);
        chk("rst_m_ack",    m_ack,    2'b00);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_s_req", s_req, 1'b0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Reset asserted while a write is on the slave bus.
        grant = 2'b01; m_req = 2'b01; m_cmd = 2'b01;
        m_addr[0 +: AW] = 32'h0000_0300; m_wdata[0 +: DW] = 32'h7777_7777;
        @(posedge clk); #1;
        grant = '0; m_req = '0;
        @(negedge clk);
        chk("mid_s_req_high", s_req, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_s_req", s_req, 1'b0);
        s_ack = 1'b1;
        #1;
        chk("async_rst_m_ack", m_ack, 2'b00);
        chk("async_rst_arb_ack", arb_ack, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_hold_arb_ack", arb_ack, 1'b0);
        s_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        last_rdata = '0;
        @(posedge clk); #1;
        run_vec(tbl[1]);
        run_vec(tbl[0]);

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xbar_slave_port.md
Name: xbar_slave_port

Overview:
- Slave-side stage of the cross-bar; sits directly downstream of the per-slave round-robin arbiter.
- Consumes the arbiter's one-hot grant and latches the winning master's transaction. Drives it onto the slave bus, returns ack and read data to that master only.
- Pulses ack back to the arbiter when the transaction is complete, so the arbiter may advance.

Parameters:
N, 2, number of masters; must be >= 2; equals the arbiter's N.
AW, 32, address width.
DW, 32, data width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset; asynchronous, active-low.
grant  in  N  one-hot grant from the arbiter.
arb_ack  out  1  one-cycle pulse to the arbiter when a transaction completes.
m_req  in  N  per-master request.
m_addr  in  N*AW  per-master address; master i occupies bits [i*AW +: AW].
m_cmd  in  N  per-master command: 0 = read, 1 = write.
m_wdata  in  N*DW  per-master write data; master i occupies bits [i*DW +: DW].
m_ack  out  N  per-master ack.
m_rvalid  out  N  per-master read-data-valid.
m_rdata  out  DW  read data, shared by all masters; qualified by m_rvalid.
s_req  out  1  slave request.
s_addr  out  AW  slave address.
s_cmd  out  1  slave command.
s_wdata  out  DW  slave write data.
s_ack  in  1  slave ack.
s_rdata  in  DW  slave read data; valid in the cycle after the s_ack of a read.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - s_req=0; s_addr, s_cmd, s_wdata = 0.
  - m_rdata=0, m_rvalid=0, arb_ack=0.
  - Owner index = 0.
  - Reset asserted mid-transaction drops s_req immediately; the transaction is abandoned and no ack is sent to any master.
- States: IDLE, REQ, RDATA, DONE.
- IDLE:
  - Capture happens when grant is exactly one-hot and m_req[i] is 1 for the granted i.
  - On capture: latch owner=i, plus m_addr, m_cmd, m_wdata of master i; go to REQ.
  - Grant that is zero or not one-hot, or granted master with m_req=0: no capture, stay in IDLE.
- REQ:
  - s_req=1; s_addr, s_cmd, s_wdata driven from the latched registers.
  - m_ack[owner] = s_ack, combinational pass-through; all other m_ack bits are 0.
  - s_ack=1 with cmd=write: go to DONE.
  - s_ack=1 with cmd=read: go to RDATA.
  - s_ack=0: stay in REQ with request fields held; no timeout.
- RDATA:
  - s_req=0.
  - Register s_rdata into m_rdata; go to DONE.
- DONE (exactly one cycle):
  - arb_ack=1.
  - For a read: m_rvalid[owner]=1.
  - Go to IDLE.
- m_rdata holds its last value outside DONE.
- grant and m_* inputs are ignored outside IDLE; a master still holding m_req after capture is not recaptured.
- Minimum latency:
  - Capture edge -> s_req high 1 cycle later.
  - Write: s_ack -> arb_ack 1 cycle later; one transaction every 3 cycles.
  - Read: s_ack -> m_rvalid and arb_ack 2 cycles later.
- Every cycle, at most one bit of m_ack is set and at most one bit of m_rvalid is set.

Test Plan:
1. Reset then idle: rst=0 for 5 cycles, grant=0 -> all outputs 0; s_req stays 0 after rst=1.
2. Write from master 1: grant=2'b10, m_req=2'b10, m_cmd[1]=1, addr=0x100, wdata=0xDEADBEEF; slave acks in the 3rd REQ cycle -> s_req high 3 cycles with those values; m_ack=2'b10 in the ack cycle; arb_ack pulse 1 cycle later; m_rvalid stays 0.
3. Read from master 0: grant=2'b01, addr=0x40; s_ack immediate; s_rdata=0x12345678 in the following cycle -> in DONE, m_rdata=0x12345678, m_rvalid=2'b01 and arb_ack=1 for one cycle.
4. Illegal and empty grants: grant=2'b11, then grant=2'b01 with m_req=0 -> no capture; s_req stays 0; arb_ack stays 0.
5. Grant change mid-transaction: grant switches 01->10 while in REQ -> s_addr unchanged; ack still routed only to master 0.
6. Reset during REQ: rst=0 while s_req=1 -> s_req=0 with no clock edge; no m_ack or arb_ack; the next grant is served normally.
